// File: rtl/alu_serial_sequencer.sv
// Bit-serial operation sequencer driving a single external 1-bit ALU slice.
// Operands are walked LSB first, one bit pair per cycle; the slice carry is
// chained through carry_q and the result word is reassembled in result_q.
module alu_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic             alu_out,
  input  logic             alu_cout,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpSlt = 3'b011;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic             is_addsub;
  logic             is_arith;
  logic [WIDTH-1:0] word;

  assign is_addsub = (op_q == OpAdd) || (op_q == OpSub);
  assign is_arith  = is_addsub || (op_q == OpSlt);

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      carryout_q <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      carryout_q <= carryout_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state: accept in IDLE, one slice bit per RUN cycle, flags on the MSB.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    result_d   = result_q;
    carryout_d = carryout_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    word       = result_q;
    word[idx_q] = alu_out;

    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          op_d    = op;
          a_d     = opA;
          b_d     = opB;
          idx_d   = '0;
          // Slice subtracts as a + ~b + cin, so SUB/SLT seed the carry with 1.
          carry_d = (op == OpSub) || (op == OpSlt);
          state_d = StRun;
        end
      end
      StRun: begin
        result_d = word;
        carry_d  = is_arith & alu_cout;
        idx_d    = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          // carry_q is the carry into the MSB; alu_cout is the carry out of it.
          carryout_d = is_arith & alu_cout;
          overflow_d = is_addsub & (carry_q ^ alu_cout);
          if (op_q == OpSlt) begin
            result_d    = '0;
            result_d[0] = word[WIDTH-1] ^ (carry_q ^ alu_cout);
          end
          zero_d  = (result_d == '0);
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Slice drive is gated to RUN so the slice sees zeros while idle or done.
  always_comb begin
    alu_a   = 1'b0;
    alu_b   = 1'b0;
    alu_cin = 1'b0;
    alu_op  = 3'b000;
    if (state_q == StRun) begin
      alu_a   = a_q[idx_q];
      alu_b   = b_q[idx_q];
      alu_cin = carry_q;
      alu_op  = op_q;
    end
  end

  assign start_ready  = (state_q == StIdle);
  assign result_valid = (state_q == StDone);
  assign result       = result_q;
  assign carryout     = carryout_q;
  assign zero         = zero_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural 1-bit ALU slice.
module tb_alu_serial_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic         alu_a, alu_b, alu_cin;
  logic [2:0]   alu_op;
  logic         alu_out, alu_cout;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] result;
  logic         carryout, zero, overflow;

  int checks = 0;
  int errors = 0;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .op           (op),
    .opA          (opA),
    .opB          (opB),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_cin      (alu_cin),
    .alu_op       (alu_op),
    .alu_out      (alu_out),
    .alu_cout     (alu_cout),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .carryout     (carryout),
    .zero         (zero),
    .overflow     (overflow)
  );

  always #100 clk = ~clk;

  // Reference 1-bit slice.
  logic bb;
  always_comb begin
    bb       = alu_b;
    alu_out  = 1'b0;
    alu_cout = 1'b0;
    case (alu_op)
      3'b000, 3'b001, 3'b011: begin
        if (alu_op != 3'b000) bb = ~alu_b;
        alu_out  = alu_a ^ bb ^ alu_cin;
        alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
      end
      3'b010:  alu_out = alu_a ^ alu_b;
      3'b100:  alu_out = alu_a & alu_b;
      3'b101:  alu_out = ~(alu_a & alu_b);
      3'b110:  alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a | alu_b;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op, then wait (bounded) for result_valid. cyc counts edges from accept inclusive.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic [2:0] flags, output int cyc,
                        output logic cin_seen, output logic op_bad);
    int guard = 0;
    cin_seen = 1'b0;
    op_bad   = 1'b0;
    while (!start_ready && guard < 200) begin
      tick();
      guard++;
    end
    start_valid = 1'b1;
    op  = o;
    opA = a;
    opB = b;
    tick();
    start_valid = 1'b0;
    // Scramble inputs after accept; the latched copies must be used.
    op  = ~o;
    opA = ~a;
    opB = ~b;
    cyc = 1;
    while (!result_valid && cyc < 200) begin
      cin_seen = cin_seen | alu_cin;
      if (alu_op !== o) op_bad = 1'b1;
      tick();
      cyc++;
    end
    res   = result;
    flags = {carryout, zero, overflow};
  endtask

  task automatic release_result;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    #50;
    checks++;
    if ({start_ready, result_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake actual=%b required=10", {start_ready, result_valid});
    end
    checks++;
    if ({result, carryout, zero, overflow} !== {{W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL reset_result actual=%h/%b required=0/000", result,
               {carryout, zero, overflow});
    end
    checks++;
    if ({alu_a, alu_b, alu_cin, alu_op} !== 6'b0) begin
      errors++;
      $display("FAIL reset_alu actual=%b required=000000", {alu_a, alu_b, alu_cin, alu_op});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add;
    logic [W-1:0] res;
    logic [2:0]   fl;
    int           cyc;
    logic         cs, ob;
    run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'h0) begin
      errors++;
      $display("FAIL add_result actual=%h required=00000000", res);
    end
    checks++;
    if (fl !== 3'b110) begin
      errors++;
      $display("FAIL add_flags actual=%b required=110", fl);
    end
    checks++;
    if (cyc !== W + 1) begin
      errors++;
      $display("FAIL add_latency actual=%0d required=%0d", cyc, W + 1);
    end
    checks++;
    if (ob !== 1'b0) begin
      errors++;
      $display("FAIL add_alu_op actual=bad required=stable");
    end
    release_result();
  endtask

  task automatic test_sub;
    logic [W-1:0] res;
    logic [2:0]   fl;
    int           cyc;
    logic         cs, ob;
    run_op(3'b001, 32'h8000_0000, 32'h0000_0001, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL sub_result actual=%h required=7fffffff", res);
    end
    checks++;
    if (fl !== 3'b101) begin
      errors++;
      $display("FAIL sub_flags actual=%b required=101", fl);
    end
    release_result();
  endtask

  task automatic test_slt;
    logic [W-1:0] res;
    logic [2:0]   fl;
    int           cyc;
    logic         cs, ob;
    run_op(3'b011, 32'hFFFF_FFFB, 32'h0000_0003, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'h1) begin
      errors++;
      $display("FAIL slt_lt_result actual=%h required=00000001", res);
    end
    checks++;
    if (fl !== 3'b100) begin
      errors++;
      $display("FAIL slt_lt_flags actual=%b required=100", fl);
    end
    release_result();
    run_op(3'b011, 32'h0000_0003, 32'hFFFF_FFFB, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'h0) begin
      errors++;
      $display("FAIL slt_ge_result actual=%h required=00000000", res);
    end
    checks++;
    if (fl !== 3'b010) begin
      errors++;
      $display("FAIL slt_ge_flags actual=%b required=010", fl);
    end
    release_result();
  endtask

  task automatic test_logic;
    logic [W-1:0] res;
    logic [2:0]   fl;
    int           cyc;
    logic         cs, ob;
    run_op(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'h0FFF_0FFF) begin
      errors++;
      $display("FAIL nand_result actual=%h required=0fff0fff", res);
    end
    checks++;
    if (fl !== 3'b000) begin
      errors++;
      $display("FAIL nand_flags actual=%b required=000", fl);
    end
    checks++;
    if (cs !== 1'b0) begin
      errors++;
      $display("FAIL nand_cin actual=%b required=0", cs);
    end
    release_result();
    run_op(3'b010, 32'h1234_5678, 32'hFFFF_0000, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'hEDCB_5678) begin
      errors++;
      $display("FAIL xor_result actual=%h required=edcb5678", res);
    end
    release_result();
    run_op(3'b110, 32'h0000_FFFF, 32'h00FF_0000, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL nor_result actual=%h required=ff000000", res);
    end
    release_result();
    run_op(3'b111, 32'h0F0F_0000, 32'h0000_00F0, res, fl, cyc, cs, ob);
    checks++;
    if (res !== 32'h0F0F_00F0) begin
      errors++;
      $display("FAIL or_result actual=%h required=0f0f00f0", res);
    end
    release_result();
    run_op(3'b100, 32'h0F0F_0000, 32'hF0F0_FFFF, res, fl, cyc, cs, ob);
    checks++;
    if ({res, fl} !== {32'h0, 3'b010}) begin
      errors++;
      $display("FAIL and_zero actual=%h/%b required=00000000/010", res, fl);
    end
    release_result();
  endtask

  task automatic test_backpressure;
    logic [W-1:0] res;
    logic [2:0]   fl;
    int           cyc;
    logic         cs, ob;
    logic         bad;
    run_op(3'b000, 32'h0000_0001, 32'h0000_0002, res, fl, cyc, cs, ob);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start_valid = i[0];
      op  = 3'b111;
      opA = 32'hDEAD_BEEF;
      opB = 32'h1234_5678;
      tick();
      if (result !== 32'h3 || {carryout, zero, overflow} !== 3'b000 || result_valid !== 1'b1
          || start_ready !== 1'b0) bad = 1'b1;
    end
    start_valid = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold actual=%h/%b/%b required=00000003/1/0", result, result_valid,
               start_ready);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checks++;
    if ({start_ready, result_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release actual=%b required=10", {start_ready, result_valid});
    end
  endtask

  task automatic test_back_to_back;
    int t = 0;
    int first = -1;
    int second = -1;
    result_ready = 1'b1;
    start_valid  = 1'b1;
    op  = 3'b000;
    opA = 32'h1;
    opB = 32'h1;
    while (second < 0 && t < 200) begin
      if (start_ready) begin
        if (first < 0) first = t;
        else second = t;
      end
      tick();
      t++;
    end
    start_valid = 1'b0;
    checks++;
    if (second - first !== W + 2) begin
      errors++;
      $display("FAIL b2b_period actual=%0d required=%0d", second - first, W + 2);
    end
    t = 0;
    while (!start_ready && t < 200) begin
      tick();
      t++;
    end
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] res;
    logic [2:0]   fl;
    int           cyc;
    logic         cs, ob;
    start_valid = 1'b1;
    op  = 3'b000;
    opA = 32'hFFFF_FFFF;
    opB = 32'h0000_0003;
    tick();
    start_valid = 1'b0;
    repeat (12) tick();
    #20;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_ready, result_valid, result, carryout, zero, overflow} !==
        {2'b10, {W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL midreset_outputs actual=%b%b/%h/%b required=10/00000000/000", start_ready,
               result_valid, result, {carryout, zero, overflow});
    end
    checks++;
    if ({alu_a, alu_b, alu_cin, alu_op} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_alu actual=%b required=000000", {alu_a, alu_b, alu_cin, alu_op});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_op(3'b000, 32'h0000_0005, 32'h0000_0007, res, fl, cyc, cs, ob);
    checks++;
    if ({res, fl} !== {32'hC, 3'b000}) begin
      errors++;
      $display("FAIL postreset_add actual=%h/%b required=0000000c/000", res, fl);
    end
    checks++;
    if (cyc !== W + 1) begin
      errors++;
      $display("FAIL postreset_latency actual=%0d required=%0d", cyc, W + 1);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
# alu_serial_sequencer

Bit-serial operation sequencer that drives one external 1-bit ALU slice (op encoding 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR).

- Accepts a WIDTH-bit operation over a valid/ready handshake.
- Presents one operand bit pair per cycle, LSB first, and chains the slice carry through a register.
- Reassembles the result word and derives carryout/zero/overflow flags.
- Sits between the CPU datapath and a single slice, trading latency for area.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_valid  in  1  operation request
- start_ready  out  1  sequencer can accept a request
- op  in  3  operation code, sampled on accept
- opA  in  WIDTH  operand A, sampled on accept
- opB  in  WIDTH  operand B, sampled on accept
- alu_a  out  1  operand A bit to slice
- alu_b  out  1  operand B bit to slice
- alu_cin  out  1  carry-in to slice
- alu_op  out  3  op code to slice
- alu_out  in  1  slice result bit (combinational from alu_* outputs)
- alu_cout  in  1  slice carry-out
- result_valid  out  1  result and flags are valid
- result_ready  in  1  consumer accepts result
- result  out  WIDTH  result word
- carryout  out  1  final carry-out
- zero  out  1  result == 0
- overflow  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- start_ready = (state == IDLE). result_valid = (state == DONE).
- IDLE:
  - On start_valid: latch op/opA/opB, idx ← 0, go RUN.
  - Initial carry: 1 for SUB/SLT (slice computes a + ~b + cin), else 0.
- RUN, per cycle:
  - Drive alu_a = A[idx], alu_b = B[idx], alu_cin = carry, alu_op = op.
  - At the clock edge: result[idx] ← alu_out.
  - carry ← alu_cout for ADD/SUB/SLT; carry ← 0 for logic ops.
  - idx ← idx+1.
- MSB handling (idx == WIDTH-1):
  - Capture cmsb = alu_cin and the final alu_cout; go DONE.
- Flags, registered on entry to DONE:
  - carryout = final cout for ADD/SUB/SLT, else 0.
  - overflow = cmsb XOR cout for ADD/SUB, else 0.
  - SLT: result = {WIDTH-1 zeros, diff[MSB] XOR (cmsb XOR cout)}; overflow = 0; carryout = subtraction cout.
  - zero = (final result == 0), computed on the final result word.
- DONE:
  - result/flags held stable while result_ready is low.
  - On result_ready: go IDLE.
- start_valid outside IDLE is ignored, not queued.
- Latched operands are unaffected by opA/opB changes after accept.
- alu_a/alu_b/alu_cin/alu_op drive 0 outside RUN.
- Reset (any time, including mid-RUN): state IDLE, idx 0, carry 0, result 0, carryout/zero/overflow 0, result_valid 0, start_ready 1, all alu_* 0. The in-flight operation is discarded.

## Timing
- Accept on edge E0 (start_valid & start_ready).
- RUN occupies exactly WIDTH cycles (edges E1..E_WIDTH).
- result_valid high from edge E_WIDTH onward, i.e. WIDTH+1 cycles after accept.
- Earliest next accept is the cycle after result_valid & result_ready.
- Back-to-back throughput: one op per WIDTH+2 cycles.
- The slice is combinational. Clock period must exceed slice propagation from alu_* to alu_out/alu_cout (gate-delay model); the bench uses a period of 200 time units.
- No combinational path from start_valid to start_ready, or from result_ready to result_valid.

## Test plan
- ADD opA=0xFFFFFFFF, opB=0x00000001 → result 0x00000000, carryout 1, zero 1, overflow 0; result_valid exactly 33 cycles after accept.
- SUB opA=0x80000000, opB=0x00000001 → result 0x7FFFFFFF, carryout 1, overflow 1, zero 0.
- SLT opA=0xFFFFFFFB (-5), opB=0x00000003 → result 0x00000001; swapped operands → result 0x00000000, zero 1.
- NAND opA=0xF0F0F0F0, opB=0xFF00FF00 → result 0x0FFF0FFF, carryout 0, overflow 0; alu_cin 0 throughout RUN.
- Backpressure:
  - Hold result_ready low 10 cycles after result_valid → result/flags unchanged, start_ready 0, start_valid pulses ignored.
  - Raise result_ready → IDLE next cycle.
- Reset mid-operation:
  - Assert rst_n low asynchronously at idx 12 of an ADD → all outputs take reset values immediately.
  - After release, ADD 0x00000005 + 0x00000007 → 0x0000000C, latency unchanged.
